// File: rtl/apb_uart_fifo_core_if.sv
// APB slave bus bundle for apb_uart_fifo_core: select/enable/direction/address/data plus response.
interface apb_uart_fifo_core_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [1:0]  PADDR;
  logic [15:0] PWDATA;
  logic [15:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_uart_fifo_core.sv
// APB UART with TX/RX FIFOs, 16x-oversampled receiver, sticky error flags and maskable IRQ.
// Parity generation/checking (CTRL[6:5], STATUS[6]) is built only when UART_PARITY_EN is defined.
module apb_uart_fifo_core #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter logic [15:0] DIV_RST    = 16'd26
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_uart_fifo_core_if.slave apb,
  input  logic                RX,
  output logic                TX,
  output logic                IRQ
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned BIT_W = 4;
`ifdef UART_PARITY_EN
  localparam logic [6:0] CTRL_MASK = 7'h7F;
`else
  localparam logic [6:0] CTRL_MASK = 7'h1F;
`endif

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  logic              w_acc, w_data_wr, w_data_rd, w_stat_wr, w_baud_wr, w_ctrl_wr;
  logic [DIV_W-1:0]  r_baud, r_tick_cnt;
  logic              w_tick;
  logic [6:0]        r_ctrl;

  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_tx_wp, r_tx_rp;
  logic              w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_go, w_tx_load;
  logic [DATA_W-1:0] w_tx_head;

  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_rx_wp, r_rx_rp;
  logic              w_rx_empty, w_rx_full, w_rx_push, w_rx_push_req, w_rx_pop;
  logic [DATA_W-1:0] w_rx_head;

  tx_state_t         r_tx_state, w_tx_state_nxt;
  logic [3:0]        r_tx_ph, w_tx_ph_nxt;
  logic [BIT_W-1:0]  r_tx_bit, w_tx_bit_nxt;
  logic [DATA_W-1:0] r_tx_shr, w_tx_shr_nxt;
  logic              w_tx_end, w_tx_line, r_tx;

  rx_state_t         r_rx_state, w_rx_state_nxt;
  logic [3:0]        r_rx_ph, w_rx_ph_nxt;
  logic [BIT_W-1:0]  r_rx_bit, w_rx_bit_nxt;
  logic [DATA_W-1:0] r_rx_shr, w_rx_shr_nxt;
  logic              r_rx_s1, r_rx_s2, r_rx_d, w_rx_fall, w_rx_end;

  logic              w_frm_set, w_ovr_set, r_ovr, r_frm, r_par, r_irq;
  logic [15:0]       w_status, w_prdata;

`ifdef UART_PARITY_EN
  logic              w_par_en, w_par_odd, w_par_set, r_tx_par;
  assign w_par_en  = r_ctrl[5];
  assign w_par_odd = r_ctrl[6];
`endif

  // APB decode; an access completes on the PSEL&PENABLE edge
  assign w_acc     = apb.PSEL & apb.PENABLE;
  assign w_data_wr = w_acc &  apb.PWRITE & (apb.PADDR == 2'd0);
  assign w_data_rd = w_acc & ~apb.PWRITE & (apb.PADDR == 2'd0);
  assign w_stat_wr = w_acc &  apb.PWRITE & (apb.PADDR == 2'd1);
  assign w_baud_wr = w_acc &  apb.PWRITE & (apb.PADDR == 2'd2);
  assign w_ctrl_wr = w_acc &  apb.PWRITE & (apb.PADDR == 2'd3);

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]) & (r_tx_wp[AW] != r_tx_rp[AW]);
  assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];
  assign w_tx_push  = w_data_wr & (~w_tx_full | w_tx_pop);
  assign w_tx_go    = ~w_tx_empty & r_ctrl[0];

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]) & (r_rx_wp[AW] != r_rx_rp[AW]);
  assign w_rx_head  = r_rx_mem[r_rx_rp[AW-1:0]];
  assign w_rx_pop   = w_data_rd & ~w_rx_empty;
  assign w_rx_push  = w_rx_push_req & (~w_rx_full | w_rx_pop);
  assign w_ovr_set  = w_rx_push_req & w_rx_full & ~w_rx_pop;

  assign w_tick    = (r_tick_cnt == r_baud);
  assign w_tx_end  = w_tick & (r_tx_ph == 4'd15);
  assign w_rx_end  = w_tick & (r_rx_ph == 4'd15);
  assign w_rx_fall = r_rx_d & ~r_rx_s2;

  always_ff @(posedge PCLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= apb.PWDATA[DATA_W-1:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_shr;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
    end
  end

  // Config registers and the 16x tick divider (period BAUD+1, restarted by a BAUD write)
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_baud     <= DIV_W'(DIV_RST);
      r_ctrl     <= '0;
      r_tick_cnt <= '0;
    end else begin
      if (w_baud_wr) r_baud <= apb.PWDATA[DIV_W-1:0];
      if (w_ctrl_wr) r_ctrl <= apb.PWDATA[6:0] & CTRL_MASK;
      if (w_baud_wr || w_tick) r_tick_cnt <= '0;
      else                     r_tick_cnt <= r_tick_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_ph_nxt    = r_tx_ph;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shr_nxt   = r_tx_shr;
    w_tx_pop       = 1'b0;
    w_tx_load      = 1'b0;
    w_tx_line      = 1'b1;
    if (r_tx_state != TX_IDLE && w_tick) w_tx_ph_nxt = r_tx_ph + 4'd1;
    case (r_tx_state)
      TX_IDLE: w_tx_load = w_tx_go;
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_end) w_tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        w_tx_line = r_tx_shr[0];
        if (w_tx_end) begin
          w_tx_shr_nxt = r_tx_shr >> 1;
          w_tx_bit_nxt = r_tx_bit + BIT_W'(1);
          if (r_tx_bit == BIT_W'(DATA_W - 1)) begin
            w_tx_bit_nxt = '0;
`ifdef UART_PARITY_EN
            w_tx_state_nxt = w_par_en ? TX_PARITY : TX_STOP;
`else
            w_tx_state_nxt = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        w_tx_line = r_tx_par;
        if (w_tx_end) w_tx_state_nxt = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (w_tx_end) begin
          if (w_tx_go) w_tx_load = 1'b1;
          else         w_tx_state_nxt = TX_IDLE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    // Starting a frame (from IDLE or back-to-back after STOP) pops the FIFO head
    if (w_tx_load) begin
      w_tx_state_nxt = TX_START;
      w_tx_pop       = 1'b1;
      w_tx_shr_nxt   = w_tx_head;
      w_tx_ph_nxt    = '0;
      w_tx_bit_nxt   = '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tx_state <= TX_IDLE;
      r_tx_ph    <= '0;
      r_tx_bit   <= '0;
      r_tx_shr   <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_ph    <= w_tx_ph_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shr   <= w_tx_shr_nxt;
      r_tx       <= w_tx_line;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)         r_tx_par <= 1'b0;
    else if (w_tx_load) r_tx_par <= (^w_tx_head) ^ w_par_odd;
  end
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  // Receiver: validate start at mid-bit (phase 7), then sample every 16 ticks at bit centres
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_ph_nxt    = r_rx_ph;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shr_nxt   = r_rx_shr;
    w_rx_push_req  = 1'b0;
    w_frm_set      = 1'b0;
`ifdef UART_PARITY_EN
    w_par_set      = 1'b0;
`endif
    if (r_rx_state != RX_IDLE && w_tick) w_rx_ph_nxt = r_rx_ph + 4'd1;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_ctrl[1] && w_rx_fall) begin
          w_rx_state_nxt = RX_START;
          w_rx_ph_nxt    = '0;
        end
      end
      RX_START: begin
        if (w_tick && r_rx_ph == 4'd7) begin
          w_rx_ph_nxt    = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_end) begin
          w_rx_shr_nxt = {r_rx_s2, r_rx_shr[DATA_W-1:1]};
          w_rx_bit_nxt = r_rx_bit + BIT_W'(1);
          if (r_rx_bit == BIT_W'(DATA_W - 1)) begin
            w_rx_bit_nxt = '0;
`ifdef UART_PARITY_EN
            w_rx_state_nxt = w_par_en ? RX_PARITY : RX_STOP;
`else
            w_rx_state_nxt = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (w_rx_end) begin
          w_par_set      = r_rx_s2 != ((^r_rx_shr) ^ w_par_odd);
          w_rx_state_nxt = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (w_rx_end) begin
          w_frm_set      = ~r_rx_s2;
          w_rx_push_req  = r_rx_s2;
          w_rx_state_nxt = RX_IDLE;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_rx_state <= RX_IDLE;
      r_rx_ph    <= '0;
      r_rx_bit   <= '0;
      r_rx_shr   <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_ph    <= w_rx_ph_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shr   <= w_rx_shr_nxt;
    end
  end

  // Sticky error flags: a new error in the same cycle wins over write-1-to-clear
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ovr <= 1'b0;
      r_frm <= 1'b0;
      r_par <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ovr_set)                          r_ovr <= 1'b1;
      else if (w_stat_wr && apb.PWDATA[4])    r_ovr <= 1'b0;
      if (w_frm_set)                          r_frm <= 1'b1;
      else if (w_stat_wr && apb.PWDATA[5])    r_frm <= 1'b0;
`ifdef UART_PARITY_EN
      if (w_par_set)                          r_par <= 1'b1;
      else if (w_stat_wr && apb.PWDATA[6])    r_par <= 1'b0;
`else
      if (w_stat_wr && apb.PWDATA[6])         r_par <= 1'b0;
`endif
      r_irq <= (r_ctrl[2] & ~w_rx_empty) | (r_ctrl[3] & w_tx_empty) |
               (r_ctrl[4] & (r_ovr | r_frm | r_par));
    end
  end

  assign w_status = {9'd0, r_par, r_frm, r_ovr, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};

  always_comb begin
    w_prdata = '0;
    if (w_acc) begin
      case (apb.PADDR)
        2'd0:    w_prdata = w_rx_empty ? 16'd0 : 16'(w_rx_head);
        2'd1:    w_prdata = w_status;
        2'd2:    w_prdata = 16'(r_baud);
        default: w_prdata = 16'(r_ctrl);
      endcase
    end
  end

  assign apb.PRDATA  = w_prdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = (w_data_wr & w_tx_full & ~w_tx_pop) | (w_data_rd & w_rx_empty);
  assign TX          = r_tx;
  assign IRQ         = r_irq;
endmodule
